// File: rtl/result_scoreboard_if.sv
// Expected-word and DUT-word streams seen by the result scoreboard.
// Both streams transfer a word on a rising clock edge where valid && ready; data is held with valid until then.
interface result_scoreboard_if #(
  parameter int DATA_W = 32
);
  logic              exp_valid;
  logic              exp_ready;
  logic [DATA_W-1:0] exp_data;
  logic              act_valid;
  logic              act_ready;
  logic [DATA_W-1:0] act_data;

  modport master (
    output exp_valid, exp_data, act_valid, act_data,
    input  exp_ready, act_ready
  );

  modport slave (
    input  exp_valid, exp_data, act_valid, act_data,
    output exp_ready, act_ready
  );
endinterface

// File: rtl/result_scoreboard.sv
// In-order hardware scoreboard: buffers expected words, compares them against DUT words,
// and counts passes and failures until num_tests comparisons have been made.
module result_scoreboard #(
  parameter int DATA_W    = 32,
  parameter int EXP_DEPTH = 16,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_tests,
  result_scoreboard_if.slave sb,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              mismatch,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic              done,
  output logic [1:0]        fsm_state
);
  localparam int AW = $clog2(EXP_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  num_tests_q;
  logic [DATA_W-1:0] mem [EXP_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, empty, push, pop, match, last;
  logic [CNT_W-1:0]  total;

  assign full  = (count == (AW+1)'(EXP_DEPTH));
  assign empty = (count == '0);

  assign sb.exp_ready = (state_q == RUN) && !full;
  assign sb.act_ready = (state_q == RUN) && !empty;

  // A start pulse overrides any handshake presented in the same cycle.
  assign push  = sb.exp_valid && sb.exp_ready && !start;
  assign pop   = sb.act_valid && sb.act_ready && !start;
  assign match = (mem[rd_ptr] == sb.act_data);
  assign total = pass_cnt + fail_cnt;
  assign last  = ((total + CNT_W'(1)) == num_tests_q);

  assign done      = (state_q == DONE);
  assign fsm_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (num_tests == '0) ? DONE : RUN;
      RUN: begin
        if (start)            state_d = (num_tests == '0) ? DONE : RUN;
        else if (pop && last) state_d = DONE;
      end
      DONE: if (start) state_d = (num_tests == '0) ? DONE : RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sb.exp_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_tests_q    <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      mismatch       <= 1'b0;
      first_fail_idx <= '0;
    end else if (start) begin
      num_tests_q    <= num_tests;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      mismatch       <= 1'b0;
      first_fail_idx <= '0;
    end else begin
      mismatch <= pop && !match;
      if (pop) begin
        if (match) begin
          pass_cnt <= pass_cnt + CNT_W'(1);
        end else begin
          fail_cnt <= fail_cnt + CNT_W'(1);
          // Index is the pre-increment comparison count of the first failure.
          if (fail_cnt == '0) first_fail_idx <= total;
        end
      end
    end
  end
endmodule

// File: tb/tb_result_scoreboard.sv
// Directed bench for result_scoreboard: reset, all-pass, mixed, backpressure, stall and restart runs.
module tb_result_scoreboard;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;
  localparam int BUDGET = 200;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_tests = '0;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, first_fail_idx;
  logic             mismatch, done;
  logic [1:0]       fsm_state;

  int n_cmp = 0;
  int n_err = 0;
  int mis_seen = 0;
  int mis_base = 0;

  result_scoreboard_if #(.DATA_W(DATA_W)) sb ();

  result_scoreboard #(.DATA_W(DATA_W), .EXP_DEPTH(16), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_tests      (num_tests),
    .sb             (sb.slave),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .mismatch       (mismatch),
    .first_fail_idx (first_fail_idx),
    .done           (done),
    .fsm_state      (fsm_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && mismatch) mis_seen++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n);
    @(negedge clk);
    start = 1'b1;
    num_tests = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    sb.exp_valid = 1'b1;
    sb.exp_data  = d;
    while (!sb.exp_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) check("exp_ready_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    sb.exp_valid = 1'b0;
  endtask

  task automatic drive_act(input logic [DATA_W-1:0] d, input logic exp_mis);
    int n;
    n = 0;
    @(negedge clk);
    sb.act_valid = 1'b1;
    sb.act_data  = d;
    while (!sb.act_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) check("act_ready_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    sb.act_valid = 1'b0;
    check("mismatch_pulse", {63'd0, mismatch}, {63'd0, exp_mis});
  endtask

  initial begin
    sb.exp_valid = 1'b0;
    sb.exp_data  = '0;
    sb.act_valid = 1'b0;
    sb.act_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_pass", 64'(pass_cnt), 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_ready", {62'd0, sb.exp_ready, sb.act_ready}, 64'd0);
    rst_n = 1'b1;

    // 1: reset mid-run with three passes recorded
    do_start(8);
    for (int i = 0; i < 3; i++) push_exp(32'h100 + i);
    for (int i = 0; i < 3; i++) drive_act(32'h100 + i, 1'b0);
    check("t1_pass_before", 64'(pass_cnt), 64'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t1_pass", 64'(pass_cnt), 64'd0);
    check("t1_fail", 64'(fail_cnt), 64'd0);
    check("t1_state", 64'(fsm_state), 64'd0);
    check("t1_ready", {62'd0, sb.exp_ready, sb.act_ready}, 64'd0);
    check("t1_flags", {62'd0, done, mismatch}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2: all pass
    mis_base = mis_seen;
    do_start(8);
    for (int i = 0; i < 8; i++) push_exp(32'(i));
    for (int i = 0; i < 7; i++) drive_act(32'(i), 1'b0);
    check("t2_done_early", {63'd0, done}, 64'd0);
    drive_act(32'd7, 1'b0);
    check("t2_pass", 64'(pass_cnt), 64'd8);
    check("t2_fail", 64'(fail_cnt), 64'd0);
    check("t2_done", {63'd0, done}, 64'd1);
    check("t2_pulses", 64'(mis_seen - mis_base), 64'd0);

    // 3: mixed A,X,C,Y,E against A..E
    mis_base = mis_seen;
    do_start(5);
    check("t3_cleared", {63'd0, done}, 64'd0);
    push_exp(32'hAAAA_0001); push_exp(32'hBBBB_0002); push_exp(32'hCCCC_0003);
    push_exp(32'hDDDD_0004); push_exp(32'hEEEE_0005);
    drive_act(32'hAAAA_0001, 1'b0);
    drive_act(32'hBBBB_0003, 1'b1);
    drive_act(32'hCCCC_0003, 1'b0);
    drive_act(32'h5DDD_0004, 1'b1);
    drive_act(32'hEEEE_0005, 1'b0);
    check("t3_pass", 64'(pass_cnt), 64'd3);
    check("t3_fail", 64'(fail_cnt), 64'd2);
    check("t3_first_idx", 64'(first_fail_idx), 64'd1);
    check("t3_done", {63'd0, done}, 64'd1);
    check("t3_pulses", 64'(mis_seen - mis_base), 64'd2);

    // 4: backpressure at full; a push beside a pop at full must be refused
    do_start(17);
    for (int i = 0; i < 15; i++) push_exp(32'h200 + i);
    @(negedge clk);
    check("t4_ready_15", {63'd0, sb.exp_ready}, 64'd1);
    push_exp(32'h20F);
    @(negedge clk);
    check("t4_ready_full", {63'd0, sb.exp_ready}, 64'd0);
    sb.exp_valid = 1'b1;
    sb.exp_data  = 32'hDEAD_BEEF;
    sb.act_valid = 1'b1;
    sb.act_data  = 32'h200;
    @(posedge clk);
    #1;
    sb.exp_valid = 1'b0;
    sb.act_valid = 1'b0;
    check("t4_pass_1", 64'(pass_cnt), 64'd1);
    for (int i = 1; i < 16; i++) drive_act(32'h200 + i, 1'b0);
    check("t4_pass_16", 64'(pass_cnt), 64'd16);
    push_exp(32'h210);
    drive_act(32'h210, 1'b0);
    check("t4_pass_17", 64'(pass_cnt), 64'd17);
    check("t4_fail", 64'(fail_cnt), 64'd0);
    check("t4_done", {63'd0, done}, 64'd1);

    // 5: DUT word waiting on an empty FIFO
    do_start(1);
    @(negedge clk);
    sb.act_valid = 1'b1;
    sb.act_data  = 32'h55;
    repeat (3) @(negedge clk);
    check("t5_act_ready", {63'd0, sb.act_ready}, 64'd0);
    check("t5_pass_0", 64'(pass_cnt), 64'd0);
    sb.exp_valid = 1'b1;
    sb.exp_data  = 32'h55;
    @(posedge clk);
    #1;
    sb.exp_valid = 1'b0;
    @(posedge clk);
    #1;
    sb.act_valid = 1'b0;
    check("t5_pass_1", 64'(pass_cnt), 64'd1);
    check("t5_done", {63'd0, done}, 64'd1);

    // 6: zero-length run, then restart in the middle of a run
    do_start(0);
    check("t6_zero_done", {63'd0, done}, 64'd1);
    check("t6_zero_pass", 64'(pass_cnt), 64'd0);
    do_start(4);
    for (int i = 0; i < 3; i++) push_exp(32'h300 + i);
    drive_act(32'h300, 1'b0);
    drive_act(32'h301, 1'b0);
    check("t6_mid_pass", 64'(pass_cnt), 64'd2);
    do_start(2);
    check("t6_restart_pass", 64'(pass_cnt), 64'd0);
    check("t6_restart_empty", {63'd0, sb.act_ready}, 64'd0);
    push_exp(32'h400);
    push_exp(32'h401);
    drive_act(32'h400, 1'b0);
    drive_act(32'h401, 1'b0);
    check("t6_final_pass", 64'(pass_cnt), 64'd2);
    check("t6_final_done", {63'd0, done}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
